// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: formats load data, selects the writeback value,
// suppresses r0 writes, flags reserved load encodings and keeps bring-up
// retire/load counters. Every output comes straight from a flop.
module mem_wb_stage #(
  parameter int DATA_W = 16,
  parameter int RD_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [1:0]        memRead,
  input  logic              in_regWrite,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [DATA_W-1:0] in_aluResult,
  input  logic [DATA_W-1:0] readData,
  output logic              wb_valid,
  output logic              wb_regWrite,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              bad_op,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [CNT_W-1:0]  load_cnt
);

  localparam logic [1:0] LoadNone = 2'b00;
  localparam logic [1:0] LoadWord = 2'b01;
  localparam logic [1:0] LoadByte = 2'b10;
  localparam logic [1:0] LoadRsvd = 2'b11;

  logic [7:0]        loadByte;
  logic [DATA_W-1:0] nextData;
  logic              nextRegWrite;
  logic              isLoad;
  logic              isRsvd;

  // Select the writeback value and decode the load type for the MEM instruction.
  always_comb begin
    loadByte     = in_aluResult[0] ? readData[15:8] : readData[7:0];
    nextData     = in_aluResult;
    isLoad       = 1'b0;
    isRsvd       = 1'b0;
    case (memRead)
      LoadWord: begin
        nextData = readData;
        isLoad   = 1'b1;
      end
      LoadByte: begin
        nextData = {{(DATA_W-8){loadByte[7]}}, loadByte};
        isLoad   = 1'b1;
      end
      LoadRsvd: isRsvd = 1'b1;
      LoadNone: nextData = in_aluResult;
      default:  nextData = in_aluResult;
    endcase
    // r0 is hardwired: never issue a write to it.
    nextRegWrite = in_valid & in_regWrite & (in_rd != '0);
  end

  // Pipeline register with reset > flush > stall > capture priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid    <= 1'b0;
      wb_regWrite <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      bad_op      <= 1'b0;
      retired_cnt <= '0;
      load_cnt    <= '0;
    end else if (flush) begin
      wb_valid    <= 1'b0;
      wb_regWrite <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
    end else if (!stall) begin
      wb_valid    <= in_valid;
      wb_regWrite <= nextRegWrite;
      wb_rd       <= in_rd;
      wb_data     <= nextData;
      if (in_valid) begin
        retired_cnt <= retired_cnt + 1'b1;
        if (isLoad) load_cnt <= load_cnt + 1'b1;
        if (isRsvd) bad_op <= 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Pipeline register between the data memory stage and register writeback. Captures the memory read data (`readData` of the data memory), the ALU result and the writeback controls of the instruction in MEM, formats load data (word, or sign-extended byte) and selects the writeback value. It supports stall and flush, suppresses writes to r0, flags reserved load encodings, and keeps retire and load counters for bring-up.

## Interface
- `DATA_W`, 16: datapath width.
- `RD_W`, 4: destination register index width.
- `CNT_W`, 16: width of the retire and load counters.

- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `stall`  in  1: hold all registered state.
- `flush`  in  1: squash the instruction being captured.
- `in_valid`  in  1: MEM stage holds a real instruction.
- `memRead`  in  2: load type. 00 none, 01 word, 10 byte, 11 reserved.
- `in_regWrite`  in  1: instruction writes a register.
- `in_rd`  in  RD_W: destination register.
- `in_aluResult`  in  DATA_W: ALU result, also the memory address.
- `readData`  in  DATA_W: data memory read data, valid in the same cycle as the address.
- `wb_valid`  out  1: registered valid.
- `wb_regWrite`  out  1: register-file write enable.
- `wb_rd`  out  RD_W: register-file write index.
- `wb_data`  out  DATA_W: register-file write data.
- `bad_op`  out  1: sticky reserved-encoding flag.
- `retired_cnt`  out  CNT_W: count of captured valid instructions.
- `load_cnt`  out  CNT_W: count of captured valid loads.

## Operation
- Combinational next-data selection:
  - `memRead` 01: `readData`.
  - `memRead` 10: byte select is `in_aluResult[0]`. Value 0 takes `readData[7:0]`, value 1 takes `readData[15:8]`. The byte is sign-extended to DATA_W.
  - `memRead` 00 or 11: `in_aluResult`.
- Next write enable is `in_valid & in_regWrite & (in_rd != 0)`. A write to r0 is never issued, although `wb_rd` and `wb_data` are still captured.
- Update priority per edge, highest first:
  1. `rst`: `wb_valid`, `wb_regWrite`, `wb_rd`, `wb_data`, `bad_op`, `retired_cnt` and `load_cnt` all go to 0.
  2. `flush`: `wb_valid` and `wb_regWrite` go to 0, `wb_data` and `wb_rd` go to 0. Counters and `bad_op` are unchanged.
  3. `stall`: all state holds. The input instruction is not captured and not counted.
  4. Otherwise (capture): `wb_valid` takes `in_valid` and the other outputs take their next values.
- Counters advance only on a capture with `in_valid`=1:
  - `retired_cnt` increments by 1.
  - `load_cnt` increments when `memRead` is 01 or 10.
  - Both counters wrap from all-ones to 0 with no saturation.
- `bad_op` sets on a capture with `in_valid`=1 and `memRead`=11. Only `rst` clears it. A reserved load does not count toward `load_cnt`.
- Inputs with `in_valid`=0 are still captured on a capture edge, but `wb_regWrite` is 0 and nothing is counted or flagged.

## Timing
- Latency is 1 cycle: inputs present before edge N appear on the outputs after edge N.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Reset is synchronous: an asserted `rst` takes effect at the next edge and overrides simultaneous `flush` and `stall`.
- `flush` together with `stall`: flush wins and the register empties.
- A stall held for K cycles keeps the outputs constant for K cycles. The first edge with `stall`=0 captures the inputs present at that edge.
- `rst` asserted in the middle of a stall clears the register. The stalled instruction is lost, and upstream is responsible for replaying it.
- A store (`memRead`=00, `in_regWrite`=0) passes through as a valid non-writing entry and counts in `retired_cnt`.

## Test plan
- Reset, then word load: `rst` high for 2 cycles, then a capture with `in_valid`=1, `memRead`=01, `in_aluResult`=0x0002, `readData`=0x1234, `in_rd`=3, `in_regWrite`=1.
  - After reset: all outputs 0.
  - One edge after the capture: `wb_valid`=1, `wb_regWrite`=1, `wb_rd`=3, `wb_data`=0x1234, `retired_cnt`=1, `load_cnt`=1.
- Byte loads:
  - `memRead`=10, address 0x0002, `readData`=0x0E1A: `wb_data`=0x001A.
  - Address 0x0003, `readData`=0x8E1A: `wb_data`=0xFF8E.
  - Address 0x0004, `readData`=0x00F0: `wb_data`=0xFFF0.
- ALU pass and r0 suppression:
  - `memRead`=00, `in_aluResult`=0xABCD, `in_rd`=5: `wb_data`=0xABCD, `wb_regWrite`=1.
  - Same instruction with `in_rd`=0: `wb_regWrite`=0 and `wb_valid`=1.
- Stall and flush:
  - Capture 0x1111, then hold `stall` for 3 cycles while the inputs change: outputs stay 0x1111 and the counters are unchanged.
  - Assert `flush` and `stall` together: the next edge gives `wb_valid`=0, `wb_regWrite`=0, `wb_data`=0.
- Reserved encoding: a valid capture with `memRead`=11 and `in_aluResult`=0x0042.
  - `wb_data`=0x0042, `bad_op`=1, `load_cnt` unchanged.
  - `bad_op` stays 1 through the next 5 captures and clears only after `rst`.
- Counter wrap and reset mid-operation:
  - With `CNT_W`=4, make 16 valid captures: `retired_cnt` reads 0.
  - Assert `rst` during a stall: after the next edge all outputs are 0.
